// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the memory responder and its word RAM.
//   WORD_W      : data word width in bits
//   mem_state_e : responder FSM states (IDLE, ACCESS, WAIT, DONE)
//   ERR_RDATA   : value returned by a read of an out-of-range address
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } mem_state_e;

   localparam logic [WORD_W-1:0] ERR_RDATA = 16'h0000;

endpackage : mem_pkg

// File: rtl/mem_sram.sv
// -----------------------------------------------------------------------------
// mem_sram
// Single-port synchronous word RAM. One operation per enabled clock edge:
// a write when we=1, otherwise a read whose data appears on rdata after the
// edge and holds until the next enabled read.
// Ports:
//   CLK   in   clock
//   en    in   operation enable
//   we    in   1 = write, 0 = read (when en=1)
//   addr  in   word address, AW bits; caller guarantees addr < DEPTH when en=1
//   wdata in   write data
//   rdata out  registered read data
// -----------------------------------------------------------------------------
module mem_sram
   import mem_pkg::*;
#(
   parameter int unsigned AW    = 10,
   parameter int unsigned DEPTH = 1024
) (
   input  logic              CLK,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [IW-1:0]     idx;

   // Upper address bits are only ever zero here because out-of-range
   // accesses never enable the RAM.
   assign idx = IW'(addr);

   // NOTE: RAM arrays get no reset; resetting them would force a flop-based
   // implementation instead of a RAM macro, and contents survive reset anyway.
   always_ff @(posedge CLK) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule : mem_sram

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the controller's memory bus. A level-sensitive
// request (MREQ_N low in IDLE) is latched, the access runs for a fixed
// number of cycles, and completion is signalled by a one-cycle MRDY pulse
// with registered read data on RDATA and an out-of-range flag on ERR.
//
// Build option:
//   MEM_WAIT_EN  defined   : W = WAIT_CYCLES wait states after ACCESS
//                undefined : W = 0, no WAIT state logic and no counter
//
// Ports:
//   CLK     in   clock, rising edge
//   CLR     in   asynchronous active-low reset
//   MREQ_N  in   access request, active-low, sampled only in IDLE
//   R_W_N   in   1 = read, 0 = write
//   ADDR    in   word address (AW bits)
//   WDATA   in   write data
//   RDATA   out  registered read data, holds until the next read or reset
//   MRDY    out  one-cycle access-complete pulse
//   ERR     out  out-of-range access, valid only with MRDY
//
// Request latched at the sampling edge; ACCESS lasts one cycle, WAIT lasts
// W cycles, and DONE (MRDY=1) is entered on the following edge.
// -----------------------------------------------------------------------------
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned AW          = 10,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MREQ_N,
   input  logic              R_W_N,
   input  logic [AW-1:0]     ADDR,
   input  logic [WORD_W-1:0] WDATA,
   output logic [WORD_W-1:0] RDATA,
   output logic              MRDY,
   output logic              ERR
);

   // One extra bit so DEPTH = 2**AW is representable.
   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

`ifdef MEM_WAIT_EN
   localparam int unsigned W  = WAIT_CYCLES;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
`else
   // WAIT_CYCLES deliberately has no effect in this build.
   localparam int unsigned W = WAIT_CYCLES * 0;
`endif

   mem_state_e        state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              rnw_q, rnw_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              oor_q, oor_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              mrdy_q, mrdy_d;
   logic              err_q, err_d;

   logic              req_in_range;
   logic              enter_done;

   logic              ram_en;
   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_rdata;

   assign req_in_range = ({1'b0, ADDR} < DEPTH_LIM);

   // ---------------------------------------------------------------------------
   // Next-state and RAM control.
   // The RAM read is launched on the sampling edge with the same address
   // being latched, so the synchronous read data is already stable during
   // ACCESS and can be captured on the DONE-entry edge even when W = 0.
   // Writes use the latched address/data in the last cycle before DONE so
   // the array updates exactly on the DONE-entry edge.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so
      // no path can leave one unassigned and infer a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      rnw_d      = rnw_q;
      wdata_d    = wdata_q;
      oor_d      = oor_q;
      rdata_d    = rdata_q;
      mrdy_d     = 1'b0;
      err_d      = 1'b0;
      enter_done = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr_q;
      ram_wdata  = wdata_q;
`ifdef MEM_WAIT_EN
      cnt_d      = cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (!MREQ_N) begin
               addr_d  = ADDR;
               rnw_d   = R_W_N;
               wdata_d = WDATA;
               oor_d   = !req_in_range;
               state_d = ACCESS;
               if (R_W_N && req_in_range) begin
                  ram_en   = 1'b1;
                  ram_addr = ADDR;
               end
            end
         end

         ACCESS: begin
            if (W == 0) begin
               enter_done = 1'b1;
            end
`ifdef MEM_WAIT_EN
            else begin
               state_d = WAIT;
               cnt_d   = CW'(W - 1);
            end
`endif
         end

`ifdef MEM_WAIT_EN
         WAIT: begin
            if (cnt_q == '0) begin
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (enter_done) begin
         state_d = DONE;
         mrdy_d  = 1'b1;
         err_d   = oor_q;
         if (rnw_q) begin
            rdata_d = oor_q ? ERR_RDATA : ram_rdata;
         end else if (!oor_q) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State register. Reset returns to IDLE and clears the outputs; because
   // the RAM write enable is decoded from the state, a reset before the
   // DONE-entry edge also cancels an in-flight write.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rnw_q   <= 1'b1;
         wdata_q <= '0;
         oor_q   <= 1'b0;
         rdata_q <= ERR_RDATA;
         mrdy_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MEM_WAIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rnw_q   <= rnw_d;
         wdata_q <= wdata_d;
         oor_q   <= oor_d;
         rdata_q <= rdata_d;
         mrdy_q  <= mrdy_d;
         err_q   <= err_d;
`ifdef MEM_WAIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign RDATA = rdata_q;
   assign MRDY  = mrdy_q;
   assign ERR   = err_q;

   mem_sram #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_sram (
      .CLK   (CLK),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule : mem_responder
